// File: rtl/seq_dect_arb_pkg.sv
// Shared types and sizing helpers for the "010" detector arbiter.
// Default-configuration widths are exported for users of the defaults.
package seq_dect_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      FEED,
      DRAIN,
      DONE
   } state_e;

   localparam int NUM_REQ_DEF   = 4;
   localparam int BURST_LEN_DEF = 8;
   localparam int CNT_W_DEF     = 4;

   function automatic int id_w(input int num_req);
      return (num_req < 2) ? 1 : $clog2(num_req);
   endfunction

   function automatic int bcnt_w(input int burst_len);
      return $clog2(burst_len + 1);
   endfunction

   localparam int ID_W   = id_w(NUM_REQ_DEF);
   localparam int BCNT_W = bcnt_w(BURST_LEN_DEF);

endpackage

// File: rtl/seq_dect_arbiter_if.sv
// Requester bus plus detector hookup for seq_dect_arbiter.
// master = requesters and detector side, slave = arbiter side.
interface seq_dect_arbiter_if
   import seq_dect_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int CNT_W   = CNT_W_DEF
);
   localparam int IW = id_w(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] bit_valid;
   logic [NUM_REQ-1:0] bit_data;
   logic [NUM_REQ-1:0] bit_last;
   logic [NUM_REQ-1:0] bit_ready;
   logic [NUM_REQ-1:0] gnt;
   logic               busy;
   logic               det_rst;
   logic               det_seq;
   logic               det_out;
   logic               done;
   logic [IW-1:0]      done_id;
   logic [CNT_W-1:0]   hit_cnt;
   logic               done_err;

   modport master (
      output req, bit_valid, bit_data, bit_last, det_out,
      input  bit_ready, gnt, busy, det_rst, det_seq, done, done_id, hit_cnt, done_err
   );

   modport slave (
      input  req, bit_valid, bit_data, bit_last, det_out,
      output bit_ready, gnt, busy, det_rst, det_seq, done, done_id, hit_cnt, done_err
   );

endinterface

// File: rtl/seq_dect_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Produces both the one-hot grant and its index.
module rr_pick
   import seq_dect_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IW      = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx,
   output logic               any
);

   int          ci;
   logic [IW-1:0] c;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves a latch.
      gnt = '0;
      idx = '0;
      any = 1'b0;
      ci  = 0;
      c   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ci = int'(ptr) + i;
         if (ci >= NUM_REQ) ci = ci - NUM_REQ;
         c = IW'(ci);
         if (!any && req[c]) begin
            any    = 1'b1;
            gnt[c] = 1'b1;
            idx    = c;
         end
      end
   end

endmodule

// File: rtl/seq_dect_arbiter.sv
// Time-shares one Mealy "010" detector among NUM_REQ serial requesters and counts hits per burst.
// Optional SEQ_DECT_ARB_LOG_EN: prints each result in simulation; ports and timing unchanged.
module seq_dect_arbiter
   import seq_dect_arb_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input logic               clk,
   input logic               rst,
   seq_dect_arbiter_if.slave bus
);

   localparam int IW = id_w(NUM_REQ);
   localparam int BW = bcnt_w(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e             state_q, state_d;
   logic [IW-1:0]      g_q, g_d;
   logic [NUM_REQ-1:0] goh_q, goh_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [BW-1:0]      bcnt_q, bcnt_d;
   logic [CNT_W-1:0]   hit_q, hit_d;
   logic               err_q, err_d;
   logic               vld_q, vld_d;
   logic               seq_q, seq_d;
   logic               det_rst_q;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      goh_d   = goh_q;
      ptr_d   = ptr_q;
      bcnt_d  = bcnt_q;
      hit_d   = hit_q;
      err_d   = err_q;
      vld_d   = 1'b0;
      seq_d   = seq_q;

      // The detector output is scored one cycle after its bit was accepted.
      if (vld_q && bus.det_out && (hit_q != CNT_MAX)) hit_d = hit_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               g_d     = pick_idx;
               goh_d   = pick_gnt;
               state_d = CLR;
            end
         end
         CLR: begin
            hit_d   = '0;
            err_d   = 1'b0;
            bcnt_d  = '0;
            state_d = FEED;
         end
         FEED: begin
            if (bus.bit_valid[g_q]) begin
               seq_d  = bus.bit_data[g_q];
               vld_d  = 1'b1;
               bcnt_d = bcnt_q + BW'(1);
               if (bus.bit_last[g_q] || (bcnt_q == BW'(BURST_LEN - 1))) state_d = DRAIN;
            end else begin
               // A gap aborts the burst rather than stalling the detector.
               err_d   = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            ptr_d   = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         g_q       <= '0;
         goh_q     <= '0;
         ptr_q     <= '0;
         bcnt_q    <= '0;
         hit_q     <= '0;
         err_q     <= 1'b0;
         vld_q     <= 1'b0;
         seq_q     <= 1'b0;
         det_rst_q <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register samples this cycle's values together.
         state_q   <= state_d;
         g_q       <= g_d;
         goh_q     <= goh_d;
         ptr_q     <= ptr_d;
         bcnt_q    <= bcnt_d;
         hit_q     <= hit_d;
         err_q     <= err_d;
         vld_q     <= vld_d;
         seq_q     <= seq_d;
         det_rst_q <= ~vld_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.gnt       = (state_q != IDLE) ? goh_q : '0;
   assign bus.bit_ready = (state_q == FEED) ? goh_q : '0;
   assign bus.det_rst   = det_rst_q;
   assign bus.det_seq   = seq_q;
   assign bus.done      = (state_q == DONE);
   assign bus.done_id   = g_q;
   assign bus.hit_cnt   = hit_q;
   assign bus.done_err  = err_q;

`ifdef SEQ_DECT_ARB_LOG_EN
   always_ff @(posedge clk) begin
      if (!rst && state_q == DONE)
         $display("time = %t | id = %d | hits = %d | err = %b", $time, g_q, hit_q, err_q);
   end
`else
`endif

endmodule

// File: tb/tb_seq_dect_arbiter.sv
// Scoreboard bench for seq_dect_arbiter: two instances (default and CNT_W=2) with a
// behavioural "010" Mealy detector attached to each.
module tb_seq_dect_arbiter;
   import seq_dect_arb_pkg::*;

   localparam int N        = NUM_REQ_DEF;
   localparam int B0       = BURST_LEN_DEF;
   localparam int B1       = 16;
   localparam int WAIT_MAX = 8 << BCNT_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_dect_arbiter_if #(.NUM_REQ(N), .CNT_W(4)) bus0 ();
   seq_dect_arbiter_if #(.NUM_REQ(N), .CNT_W(2)) bus1 ();

   seq_dect_arbiter #(.NUM_REQ(N), .BURST_LEN(B0), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   seq_dect_arbiter #(.NUM_REQ(N), .BURST_LEN(B1), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // sel routes stimulus to one instance; the other sees no requests
   logic         sel = 1'b0;
   logic [N-1:0] req = '0, bv = '0, bd = '0, bl = '0;

   assign bus0.req       = sel ? '0 : req;
   assign bus0.bit_valid = sel ? '0 : bv;
   assign bus0.bit_data  = sel ? '0 : bd;
   assign bus0.bit_last  = sel ? '0 : bl;
   assign bus1.req       = sel ? req : '0;
   assign bus1.bit_valid = sel ? bv  : '0;
   assign bus1.bit_data  = sel ? bd  : '0;
   assign bus1.bit_last  = sel ? bl  : '0;

   wire [N-1:0] rdy     = sel ? bus1.bit_ready : bus0.bit_ready;
   wire [N-1:0] gnt     = sel ? bus1.gnt       : bus0.gnt;
   wire         busy    = sel ? bus1.busy      : bus0.busy;
   wire         det_rst = sel ? bus1.det_rst   : bus0.det_rst;
   wire         done    = sel ? bus1.done      : bus0.done;

   // Reference Mealy "010" detector: S0 idle, S1 saw 0, S2 saw 01
   function automatic logic [1:0] dnext(input logic [1:0] s, input logic b);
      case (s)
         2'd1:    return b ? 2'd2 : 2'd1;
         default: return b ? 2'd0 : 2'd1;
      endcase
   endfunction

   logic [1:0] d0 = 2'd0, d1 = 2'd0;
   always @(posedge clk) d0 <= bus0.det_rst ? 2'd0 : dnext(d0, bus0.det_seq);
   always @(posedge clk) d1 <= bus1.det_rst ? 2'd0 : dnext(d1, bus1.det_seq);
   assign bus0.det_out = (d0 == 2'd2) && !bus0.det_seq;
   assign bus1.det_out = (d1 == 2'd2) && !bus1.det_seq;

   typedef struct {
      logic [ID_W-1:0] id;
      int              hits;
      bit              err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic score(input int done_v, input int id, input int hits, input int err);
      exp_t e;
      if (sb.size() == 0) begin
         check("unexpected_done", done_v, 0);
      end else begin
         e = sb.pop_front();
         check("done_id", id, int'(e.id));
         check("hit_cnt", hits, e.hits);
         check("done_err", err, int'(e.err));
      end
   endtask

   // Monitor: scores every done pulse against the next expected result
   always @(negedge clk) begin
      if (bus0.done) score(int'(bus0.done), int'(bus0.done_id), int'(bus0.hit_cnt), int'(bus0.done_err));
      if (bus1.done) score(int'(bus1.done), int'(bus1.done_id), int'(bus1.hit_cnt), int'(bus1.done_err));
   end

   // One burst on the selected instance; bits[i] is the i-th serial bit
   task automatic burst(input int id, input logic [15:0] bits, input int n, input bit use_last,
                        input bit gap, input int blen, input int hits, input bit err,
                        input logic [N-1:0] also_req);
      int   waited;
      exp_t e;
      e.id   = ID_W'(id);
      e.hits = hits;
      e.err  = err;
      sb.push_back(e);
      req     = also_req;
      req[id] = 1'b1;
      waited  = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!rdy[id] && waited < WAIT_MAX);
      check("grant_latency", waited, 2);
      check("gnt_onehot", int'(gnt), 1 << id);
      req = '0;
      for (int i = 0; i < n; i++) begin
         check("bit_ready", int'(rdy[id]), int'(i < blen));
         bv[id] = 1'b1;
         bd[id] = bits[i];
         bl[id] = use_last && (i == n - 1);
         @(negedge clk);
      end
      bv = '0;
      bd = '0;
      bl = '0;
      if (n <= blen) begin
         if (gap) @(negedge clk);
         check("drain_no_done", int'(done), 0);
         @(negedge clk);
         check("done_latency", int'(done), 1);
      end
      waited = 0;
      while (busy && waited < WAIT_MAX) begin
         @(negedge clk);
         waited++;
      end
      check("back_to_idle", int'(busy), 0);
   endtask

   initial begin
      int   nd, cyc;
      exp_t e;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_gnt", int'(bus0.gnt), 0);
      check("rst_bit_ready", int'(bus0.bit_ready), 0);
      check("rst_busy", int'(bus0.busy), 0);
      check("rst_det_rst", int'(bus0.det_rst), 1);
      check("rst_det_seq", int'(bus0.det_seq), 0);
      check("rst_done", int'(bus0.done), 0);
      check("rst_done_id", int'(bus0.done_id), 0);
      check("rst_hit_cnt", int'(bus0.hit_cnt), 0);
      check("rst_done_err", int'(bus0.done_err), 0);
      check("rst1_det_rst", int'(bus1.det_rst), 1);
      check("rst1_busy", int'(bus1.busy), 0);
      rst = 1'b0;
      @(negedge clk);

      // 0,1,0,1,0 with last -> two overlapping hits
      burst(0, 16'h000A, 5, 1'b1, 1'b0, B0, 2, 1'b0, '0);
      // 12 valid bits, no last: burst capped at 8 bits (0,1,0,0,1,0,1,0 -> 3 hits)
      burst(2, 16'h0F52, 12, 1'b0, 1'b0, B0, 3, 1'b0, '0);
      // 0,1 then a gap -> aborted, no hit; then single 0 must not inherit the "01" prefix
      burst(1, 16'h0002, 2, 1'b0, 1'b1, B0, 0, 1'b1, '0);
      burst(1, 16'h0000, 1, 1'b1, 1'b0, B0, 0, 1'b0, '0);

      // All requesters held: rr order from a fresh pointer is 0,1,2,3,0
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         e.id   = ID_W'(k % N);
         e.hits = 0;
         e.err  = 1'b0;
         sb.push_back(e);
      end
      bv  = '1;
      bl  = '1;
      bd  = '0;
      req = '1;
      nd  = 0;
      cyc = 0;
      while (nd < 5 && cyc < WAIT_MAX) begin
         @(negedge clk);
         cyc++;
         if (bus0.done) nd++;
      end
      check("rr_done_count", nd, 5);
      req = '0;
      bv  = '0;
      bl  = '0;
      repeat (2) @(negedge clk);
      check("rr_idle", int'(busy), 0);

      // CNT_W=2 instance: 0101010101 -> 4 raw hits, saturates at 3
      sel = 1'b1;
      @(negedge clk);
      burst(0, 16'h02AA, 10, 1'b1, 1'b0, B1, 3, 1'b0, '0);

      // Reset in FEED: idle next cycle, grant dropped, detector held, no done
      req[1] = 1'b1;
      cyc    = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!rdy[1] && cyc < WAIT_MAX);
      check("abort_grant_latency", cyc, 2);
      req    = '0;
      bv[1]  = 1'b1;
      bd[1]  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      bv  = '0;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_gnt", int'(gnt), 0);
      check("abort_bit_ready", int'(rdy), 0);
      check("abort_det_rst", int'(det_rst), 1);
      check("abort_done", int'(done), 0);
      rst = 1'b0;
      @(negedge clk);
      // Pointer was 1 before the reset; with req 0 and 1 pending, 0 must win now
      burst(0, 16'h0000, 1, 1'b1, 1'b0, B1, 0, 1'b0, 4'b0011);

      cyc = 0;
      while (sb.size() != 0 && cyc < WAIT_MAX) begin
         @(negedge clk);
         cyc++;
      end
      check("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
